// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: store opcodes, byte-enable width and DM size shared by the MEM stage and the controller.
package mem_stage_pkg;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;
    localparam int BE_W = 4;
    localparam int DM_WORDS_DEFAULT = 1024;
endpackage

// File: rtl/mem_stage_store_merge.sv
// store_merge: decodes sw/sh/sb into little-endian byte enables and merges the store data into the old word.
module store_merge
    import mem_stage_pkg::*;
(
    input  logic [5:0]      opcode,
    input  logic [1:0]      addr,
    input  logic [31:0]     old_word,
    input  logic [31:0]     wdata,
    output logic [BE_W-1:0] be,
    output logic [31:0]     merged
);
    logic [31:0] lanes;
    always_comb begin
        be = opcode == OP_SW ? 4'b1111 :
             opcode == OP_SH ? (addr[1] ? 4'b1100 : 4'b0011) :
             opcode == OP_SB ? 4'b0001 << addr : 4'b0000;
        // replicate the halfword/byte across every lane so be alone selects where it lands
        lanes = opcode == OP_SW ? wdata :
                opcode == OP_SH ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
        merged = old_word;
        for (int i = 0; i < BE_W; i++)
            merged[8*i +: 8] = be[i] ? lanes[8*i +: 8] : old_word[8*i +: 8];
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage with data memory, byte-lane stores and the MEM/WB register.
// Define DM_WRITE_DISPLAY_EN to print every DM write during simulation.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEFAULT,
    parameter int DM_AW    = $clog2(DM_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ins_3,
    input  logic [31:0] PC_3,
    input  logic [4:0]  regWA_3,
    input  logic [31:0] ALUout_3,
    input  logic [31:0] memWD_3,
    output logic [31:0] ins_4,
    output logic [31:0] PC_4,
    output logic [4:0]  regWA_4,
    output logic [31:0] ALUout_4,
    output logic [31:0] memRD_4
);
    logic [31:0]      dm_q [DM_WORDS];
    logic [DM_AW-1:0] idx;
    logic [31:0]      rdata, merged;
    logic [BE_W-1:0]  be;
    logic [31:0]      ins_d, ins_q, pc_d, pc_q, alu_d, alu_q, rd_d, rd_q;
    logic [4:0]       wa_d, wa_q;
    logic             unused_hi;

    assign unused_hi = ^ALUout_3[31:DM_AW+2];

    store_merge u_merge (
        .opcode   (ins_3[31:26]),
        .addr     (ALUout_3[1:0]),
        .old_word (rdata),
        .wdata    (memWD_3),
        .be       (be),
        .merged   (merged)
    );

    always_comb begin
        idx   = ALUout_3[DM_AW+1:2];
        rdata = dm_q[idx];
        ins_d = reset ? '0 : ins_3;
        pc_d  = reset ? '0 : PC_3;
        wa_d  = reset ? '0 : regWA_3;
        alu_d = reset ? '0 : ALUout_3;
        rd_d  = reset ? '0 : rdata;
    end

    always_ff @(posedge clk) begin
        ins_q <= ins_d;
        pc_q  <= pc_d;
        wa_q  <= wa_d;
        alu_q <= alu_d;
        rd_q  <= rd_d;
        if (reset)
            dm_q <= '{default: '0};
        else if (|be)
            dm_q[idx] <= merged;
    end

`ifdef DM_WRITE_DISPLAY_EN
    always_ff @(posedge clk)
        if (!reset && |be)
            $display("@%h: *%h <= %h", PC_3, {ALUout_3[31:2], 2'b00}, merged);
`endif

    assign ins_4    = ins_q;
    assign PC_4     = pc_q;
    assign regWA_4  = wa_q;
    assign ALUout_4 = alu_q;
    assign memRD_4  = rd_q;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage 4 (MEM) of the P6 five-stage MIPS core.
- Holds the data memory (DM) and executes sw/sh/sb stores using byte-lane merging.
- Reads the addressed word for loads.
- Contains the MEM/WB pipeline register whose outputs drive the WB stage directly: ins_4, PC_4, regWA_4, memRD_4, ALUout_4. WB performs the byte/half extraction using ALUout_4[1:0].

Parameters:
- DM_WORDS, 1024, number of 32-bit words in DM (4 KiB); must be a power of 2.
- DM_AW, 10, word-index width; equals log2(DM_WORDS).

Ports:
- clk  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ins_3  in  32  instruction currently in MEM.
- PC_3  in  32  PC of that instruction.
- regWA_3  in  5  destination register number.
- ALUout_3  in  32  ALU result; byte address for loads and stores.
- memWD_3  in  32  store data, already forwarded by the hazard unit.
- ins_4  out  32  registered ins_3.
- PC_4  out  32  registered PC_3.
- regWA_4  out  5  registered regWA_3.
- ALUout_4  out  32  registered ALUout_3.
- memRD_4  out  32  registered DM word read at ALUout_3.

Behaviour:
- Reset: every edge with reset=1 sets all outputs to 0 (ins_4=0 is a nop) and clears all DM words to 0. Reset has priority over stores. A store present in MEM during reset is dropped.
- Latency: exactly 1 cycle, ins_3 to ins_4. No stall or flush inputs; the register loads every non-reset cycle.
- Word index: idx = ALUout_3[DM_AW+1:2]. Higher address bits are ignored, so addresses wrap modulo DM_WORDS*4.
- Read: rdata = DM[idx], read combinationally before the write. rdata is captured into memRD_4 at the edge.
  - For non-load instructions memRD_4 still carries DM[idx]; WB ignores it.
  - A store's own memRD_4 is the pre-write word.
- Store decode from ins_3[31:26]:
  - sw = 6'b101011: byte enable 4'b1111; ALUout_3[1:0] ignored.
  - sh = 6'b101001: byte enable 4'b0011 if ALUout_3[1]=0, else 4'b1100. Data is memWD_3[15:0] placed on the selected lanes. ALUout_3[0] ignored.
  - sb = 6'b101000: byte enable 1<<ALUout_3[1:0]. Data is memWD_3[7:0] on that lane.
  - Any other opcode: byte enable 0, no write.
- Write: at the edge, DM[idx] = merge(old word, new lanes, byte enable). Disabled lanes are preserved.
- Store then load to the same word in consecutive cycles: the load sees the updated word. This needs no bypass, because the write completes at the earlier edge.
- Byte lanes are little-endian: lane 0 = bits[7:0] = address offset 0.

Optional Feature:
- Macro: DM_WRITE_DISPLAY_EN.
- Defined: on every edge where a write occurs (reset=0, byte enable nonzero), a simulation display prints "@%h: *%h <= %h". The fields are, in order:
  - PC_3
  - the word-aligned address {ALUout_3[31:2],2'b00}
  - the merged word
- Defined, no write that cycle: no output.
- Undefined: no display code is compiled; RTL behaviour is identical.

Decomposition:
- Shared package/header (also used by Controller):
  - opcode constants OP_SW, OP_SH, OP_SB
  - byte-enable width constant BE_W=4
  - DM_WORDS default
- One sub-module: store_merge (combinational).
  - Inputs: opcode, addr[1:0], old word, memWD.
  - Outputs: byte enable and merged word.
  - Instantiated once in mem_stage.

Test Plan:
- Reset: preload DM via stores, assert reset 1 cycle → all outputs 0; a subsequent load at 0x10 gives memRD_4=0.
- sw then load: sw 0x12345678 at 0x20; next cycle ins_3=lw at 0x20 → memRD_4=0x12345678 one cycle later; ALUout_4=0x20.
- sb lanes: after sw 0 at 0x40, sb 0xAA at 0x41 then sb 0xBB at 0x43 → word 0xBB00AA00. With DM_WRITE_DISPLAY_EN, the second store prints "*00000040 <= bb00aa00".
- sh upper: after sw 0x11223344 at 0x60, sh 0xBEEF at 0x62 (and separately at 0x63) → word 0xBEEF3344 in both cases.
- Wrap and non-store: sw 0xCAFEF00D at 0x1000 → readable at 0x0000. An addu with ALUout_3=0x0 → DM unchanged, memRD_4 = DM[0], and the pipeline fields pass through unchanged.
- Reset mid-store: sw 0xFFFFFFFF at 0x8 with reset=1 in the same cycle → DM[2]=0 and ins_4=0 afterward.
